// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - CPU, memory and cache-array signal bundle for cache_fill_ctrl
interface cache_fill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic                  re;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  stall;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  cache_we;
    logic [ADDR_WIDTH-1:0] cache_waddr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_set_valid;

    modport master (
        output we, re, hit, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
        input  stall, mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, cache_set_valid
    );

    modport slave (
        input  we, re, hit, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
        output stall, mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, cache_set_valid
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - cache miss/line-fill controller; CACHE_FILL_WRITE_ALLOCATE_EN enables write-allocate
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_fill_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_q, line_d;
    logic [OFF_W-1:0]      beat_q, beat_d;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
`endif

    logic                  rd_miss, wr_miss, miss;
    logic                  stall_o, mem_req_o, cache_we_o, set_valid_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o, cache_waddr_o;
    logic [DATA_WIDTH-1:0] cache_wdata_o;

    // we wins over re, so a simultaneous re&we is never a read miss
    assign rd_miss = bus.re & ~bus.we & ~bus.hit;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
    assign wr_miss = bus.we & ~bus.hit;
`else
    assign wr_miss = 1'b0;
`endif
    assign miss = rd_miss | wr_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
            pend_q  <= 1'b0;
            pdata_q <= '0;
            paddr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            paddr_q <= paddr_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        beat_d        = beat_q;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
        pend_d        = pend_q;
        pdata_d       = pdata_q;
        paddr_d       = paddr_q;
`endif
        stall_o       = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        cache_we_o    = 1'b0;
        cache_waddr_o = '0;
        cache_wdata_o = '0;
        set_valid_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.we & bus.hit) begin
                    cache_we_o    = 1'b1;
                    cache_waddr_o = bus.addr;
                    cache_wdata_o = bus.wdata;
                end else if (miss) begin
                    stall_o = 1'b1;
                    line_d  = {bus.addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    state_d = REQ;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
                    if (wr_miss) begin
                        pend_d  = 1'b1;
                        pdata_d = bus.wdata;
                        paddr_d = bus.addr;
                    end
`endif
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = line_q;
                if (bus.mem_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                stall_o = 1'b1;
                if (bus.mem_rvalid) begin
                    cache_we_o    = 1'b1;
                    cache_waddr_o = line_q | {{(ADDR_WIDTH-OFF_W){1'b0}}, beat_q};
                    cache_wdata_o = bus.mem_rdata;
                    beat_d        = beat_q + {{(OFF_W-1){1'b0}}, 1'b1};
                    if (beat_q == OFF_W'(LINE_WORDS-1)) begin
                        set_valid_o = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                stall_o = 1'b1;
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
                // merge the pending CPU word over the freshly fetched line
                if (pend_q) begin
                    cache_we_o    = 1'b1;
                    cache_waddr_o = paddr_q;
                    cache_wdata_o = pdata_q;
                    pend_d        = 1'b0;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // reset silences every strobe, including a beat arriving in the reset cycle
        if (rst) begin
            stall_o       = 1'b0;
            mem_req_o     = 1'b0;
            mem_addr_o    = '0;
            cache_we_o    = 1'b0;
            cache_waddr_o = '0;
            cache_wdata_o = '0;
            set_valid_o   = 1'b0;
        end
    end

    assign bus.stall           = stall_o;
    assign bus.mem_req         = mem_req_o;
    assign bus.mem_addr        = mem_addr_o;
    assign bus.cache_we        = cache_we_o;
    assign bus.cache_waddr     = cache_waddr_o;
    assign bus.cache_wdata     = cache_wdata_o;
    assign bus.cache_set_valid = set_valid_o;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl against a cache-contents model
module tb_cache_fill_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   sv_cnt = 0;
    int   fills  = 0;

    logic [DW-1:0] ref_arr   [logic [AW-1:0]];
    logic [DW-1:0] dut_arr   [logic [AW-1:0]];
    bit            ref_valid [logic [AW-1:0]];
    bit            dut_valid [logic [AW-1:0]];

    cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_fill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // the array as the DUT actually writes it
    always @(negedge clk) begin
        if (bus.cache_we) begin
            dut_arr[bus.cache_waddr] = bus.cache_wdata;
            we_cnt++;
        end
        if (bus.cache_set_valid) begin
            dut_valid[bus.cache_waddr & ~32'(LW-1)] = 1'b1;
            sv_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        bus.we = 0; bus.re = 0; bus.hit = 0; bus.addr = '0; bus.wdata = '0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    // complete miss: request wait of rdy_dly cycles, gap idle cycles before each beat
    task automatic do_miss(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                           input int rdy_dly, input int gap, input bit spur, input logic [DW-1:0] dbase);
        logic [AW-1:0] line;
        logic [DW-1:0] d;
        int stalls;
        int we0;
        int exp_we;
        line   = a & ~32'(LW-1);
        stalls = 0;
        we0    = we_cnt;
        exp_we = LW;
        bus.addr = a; bus.hit = 0;
        if (wr) begin bus.we = 1; bus.wdata = wd; end else bus.re = 1;
        probe;
        chk("miss_stall", bus.stall, 1);
        chk("miss_noreq", bus.mem_req, 0);
        chk("miss_nowe", bus.cache_we, 0);
        stalls += int'(bus.stall);
        tick;
        bus.addr = $urandom; bus.wdata = $urandom;
        for (int i = 0; i <= rdy_dly; i++) begin
            bus.mem_ready  = (i == rdy_dly);
            bus.mem_rvalid = spur;
            bus.mem_rdata  = $urandom;
            probe;
            chk("req_level", bus.mem_req, 1);
            chk("req_addr", bus.mem_addr, line);
            chk("req_nowe", bus.cache_we, 0);
            stalls += int'(bus.stall);
            tick;
        end
        bus.mem_ready = 0;
        for (int b = 0; b < LW; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
                probe;
                chk("gap_nowe", bus.cache_we, 0);
                chk("fill_noreq", bus.mem_req, 0);
                stalls += int'(bus.stall);
                tick;
            end
            d = (dbase != 0) ? dbase + DW'(b) : DW'($urandom);
            bus.mem_rvalid = 1; bus.mem_rdata = d;
            probe;
            chk("beat_we", bus.cache_we, 1);
            chk("beat_waddr", bus.cache_waddr, line + AW'(b));
            chk("beat_wdata", bus.cache_wdata, d);
            chk("beat_setvalid", bus.cache_set_valid, (b == LW-1));
            ref_arr[line + AW'(b)] = d;
            stalls += int'(bus.stall);
            tick;
        end
        bus.mem_rvalid = spur; bus.mem_rdata = $urandom;
        probe;
        stalls += int'(bus.stall);
`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
        if (wr) begin
            chk("merge_we", bus.cache_we, 1);
            chk("merge_waddr", bus.cache_waddr, a);
            chk("merge_wdata", bus.cache_wdata, wd);
            ref_arr[a] = wd;
            exp_we = LW + 1;
        end else
            chk("done_nowe", bus.cache_we, 0);
`else
        chk("done_nowe", bus.cache_we, 0);
`endif
        chk("done_nosv", bus.cache_set_valid, 0);
        ref_valid[line] = 1'b1;
        fills++;
        tick;
        bus.mem_rvalid = 0; bus.we = 0; bus.re = 1; bus.hit = 1; bus.addr = a;
        probe;
        chk("rehit_stall", bus.stall, 0);
        chk("rehit_noreq", bus.mem_req, 0);
        chk("rehit_nowe", bus.cache_we, 0);
        tick;
        bus.re = 0; bus.hit = 0;
        chk("stall_cycles", stalls, LW + 3 + rdy_dly + gap * LW);
        chk("we_pulses", we_cnt - we0, exp_we);
    endtask

    initial begin
        logic [DW-1:0] r;
        logic [DW-1:0] got;
        int we0;
        int sv0;
        rst = 1;
        idle_inputs();
        tick;
        probe;
        chk("rst_stall", bus.stall, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.cache_we, 0);
        chk("rst_sv", bus.cache_set_valid, 0);
        tick;
        rst = 0;
        probe;
        chk("post_rst_stall", bus.stall, 0);
        chk("post_rst_req", bus.mem_req, 0);
        chk("post_rst_we", bus.cache_we, 0);
        tick;

        do_miss(32'h13, 0, '0, 0, 0, 0, 32'hA0);

        bus.we = 1; bus.hit = 1; bus.addr = 32'h20; bus.wdata = 32'h55;
        probe;
        chk("whit_we", bus.cache_we, 1);
        chk("whit_waddr", bus.cache_waddr, 32'h20);
        chk("whit_wdata", bus.cache_wdata, 32'h55);
        chk("whit_stall", bus.stall, 0);
        chk("whit_noreq", bus.mem_req, 0);
        ref_arr[32'h20] = 32'h55;
        tick;
        idle_inputs();

`ifdef CACHE_FILL_WRITE_ALLOCATE_EN
        do_miss(32'h31, 1, 32'hBEEF, 1, 0, 0, 0);
        bus.re = 1;
        do_miss(32'h62, 1, 32'h1234, 0, 1, 1, 0);
`else
        for (int k = 0; k < 2; k++) begin
            bus.we = 1; bus.re = (k == 1); bus.hit = 0;
            bus.addr = (k == 0) ? 32'h31 : 32'h62; bus.wdata = 32'hBEEF;
            probe;
            chk("wmiss_stall", bus.stall, 0);
            chk("wmiss_we", bus.cache_we, 0);
            chk("wmiss_req", bus.mem_req, 0);
            tick;
            idle_inputs();
            probe;
            chk("wmiss_next_req", bus.mem_req, 0);
            chk("wmiss_next_stall", bus.stall, 0);
            tick;
        end
`endif

        do_miss(32'h50, 0, '0, 1, 2, 1, 0);

        we0 = we_cnt; sv0 = sv_cnt;
        bus.re = 1; bus.hit = 0; bus.addr = 32'h46;
        tick;
        bus.mem_ready = 1;
        tick;
        bus.mem_ready = 0;
        for (int b = 0; b < 2; b++) begin
            r = $urandom;
            bus.mem_rvalid = 1; bus.mem_rdata = r;
            ref_arr[32'h44 + AW'(b)] = r;
            tick;
        end
        rst = 1; bus.mem_rdata = $urandom;
        probe;
        chk("rstmid_we", bus.cache_we, 0);
        chk("rstmid_sv", bus.cache_set_valid, 0);
        chk("rstmid_stall", bus.stall, 0);
        tick;
        rst = 0; bus.re = 0;
        probe;
        chk("rstnext_we", bus.cache_we, 0);
        chk("rstnext_stall", bus.stall, 0);
        chk("rstnext_req", bus.mem_req, 0);
        tick;
        bus.mem_rdata = $urandom;
        probe;
        chk("rstnext2_we", bus.cache_we, 0);
        tick;
        idle_inputs();
        chk("rst_we_pulses", we_cnt - we0, 2);
        chk("rst_sv_pulses", sv_cnt - sv0, 0);
        chk("rst_line_invalid", dut_valid.exists(32'h44), 0);

        for (int n = 0; n < 6; n++)
            do_miss(AW'($urandom_range(0, 255)), 0, '0, $urandom_range(0, 3),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), '0);

        foreach (ref_arr[k]) begin
            got = dut_arr.exists(k) ? dut_arr[k] : 'x;
            chk("array_word", got, ref_arr[k]);
        end
        foreach (ref_valid[k])
            chk("line_valid", dut_valid.exists(k), 1);
        chk("array_size", dut_arr.num(), ref_arr.num());
        chk("valid_lines", dut_valid.num(), ref_valid.num());
        chk("setvalid_pulses", sv_cnt, fills);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
